// File: rtl/data_mem_port.sv
// data_mem_port: synchronous byte-array data memory serving single load/store requests
// from the control path, with a fixed number of wait states per access.
// Ports:
//   clk, reset               - clock; synchronous active-high reset
//   memRead, memWrite        - request strobes, sampled only while idle (both high = store)
//   address, writeData       - captured together with the request
//   readData                 - load result, held between loads
//   dataValid                - one-cycle pulse after a load completes
//   busy                     - high while an access is in progress
// Optional build macro: DMEM_INIT_PATTERN_EN
//   defined   -> reset loads mem[i] = i (truncated to DATA_WIDTH)
//   undefined -> reset clears every location to 0
module data_mem_port #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 8,
   parameter int LATENCY    = 2   // 1..15
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  memRead,
   input  logic                  memWrite,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0] writeData,
   output logic [DATA_WIDTH-1:0] readData,
   output logic                  dataValid,
   output logic                  busy
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   typedef enum logic {
      ST_IDLE,
      ST_WAIT
   } state_t;

   state_t                state, state_next;
   logic [3:0]            cnt, cnt_next;
   logic                  capture, complete;

   logic [ADDR_WIDTH-1:0] cap_addr;
   logic [DATA_WIDTH-1:0] cap_data;
   logic                  cap_wr;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Next-state logic. The counter is loaded with LATENCY-1 so that the
   // completion edge lands exactly LATENCY edges after the capture edge.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      capture    = 1'b0;
      complete   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (memRead || memWrite) begin
               capture    = 1'b1;
               cnt_next   = 4'(LATENCY - 1);
               state_next = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt == 4'd0) begin
               complete   = 1'b1;
               state_next = ST_IDLE;
            end else begin
               cnt_next = cnt - 4'd1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign busy = (state == ST_WAIT);

   always_ff @(posedge clk) begin
      if (reset) begin
         // Reset drops any in-flight access: nothing is committed, no pulse.
         state     <= ST_IDLE;
         cnt       <= 4'd0;
         cap_addr  <= '0;
         cap_data  <= '0;
         cap_wr    <= 1'b0;
         readData  <= '0;
         dataValid <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
`ifdef DMEM_INIT_PATTERN_EN
            mem[ADDR_WIDTH'(i)] <= DATA_WIDTH'(i);
`else
            mem[ADDR_WIDTH'(i)] <= '0;
`endif
         end
      end else begin
         state     <= state_next;
         cnt       <= cnt_next;
         dataValid <= complete && !cap_wr;
         if (capture) begin
            cap_addr <= address;
            cap_data <= writeData;
            // Simultaneous read+write is treated as a store.
            cap_wr   <= memWrite;
         end
         if (complete) begin
            if (cap_wr) begin
               mem[cap_addr] <= cap_data;
            end else begin
               readData <= mem[cap_addr];
            end
         end
      end
   end

endmodule

// File: tb/tb_data_mem_port.sv
// tb_data_mem_port: directed and randomized bench for data_mem_port.
// A transaction-level model (pending access + completion timestamp + byte array)
// predicts busy/dataValid/readData every cycle; directed steps pin literal values.
module tb_data_mem_port;

   localparam int AW  = 5;
   localparam int DW  = 8;
   localparam int LAT = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          memRead;
   logic          memWrite;
   logic [AW-1:0] address;
   logic [DW-1:0] writeData;
   logic [DW-1:0] readData;
   logic          dataValid;
   logic          busy;

   int checks   = 0;
   int failures = 0;

   data_mem_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LATENCY(LAT)) dut (
      .clk       (clk),
      .reset     (reset),
      .memRead   (memRead),
      .memWrite  (memWrite),
      .address   (address),
      .writeData (writeData),
      .readData  (readData),
      .dataValid (dataValid),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [DW-1:0] m_mem [32];
   bit            m_pend = 1'b0;
   bit            m_wr;
   int            m_done;
   logic [AW-1:0] m_a;
   logic [DW-1:0] m_d;
   logic [DW-1:0] e_rd;
   bit            e_dv   = 1'b0;
   bit            e_busy = 1'b0;
   int            edge_n = 0;
   bit            m_ok   = 1'b0;

   function automatic logic [DW-1:0] init_val(input int i);
`ifdef DMEM_INIT_PATTERN_EN
      return DW'(i);
`else
      return '0;
`endif
   endfunction

   always @(posedge clk) begin
      edge_n++;
      if (reset) begin
         for (int i = 0; i < 32; i++) m_mem[i] = init_val(i);
         m_pend = 1'b0;
         e_rd   = '0;
         e_dv   = 1'b0;
         m_ok   = 1'b1;
      end else begin
         e_dv = 1'b0;
         if (m_pend && edge_n == m_done) begin
            if (m_wr) m_mem[m_a] = m_d;
            else begin
               e_rd = m_mem[m_a];
               e_dv = 1'b1;
            end
            m_pend = 1'b0;
         end else if (!m_pend && (memRead || memWrite)) begin
            m_pend = 1'b1;
            m_done = edge_n + LAT;
            m_a    = address;
            m_d    = writeData;
            m_wr   = memWrite;
         end
      end
      e_busy = m_pend;
   end

   always @(negedge clk) begin
      if (m_ok) begin
         chk("model_busy", 32'(busy), 32'(e_busy));
         chk("model_dataValid", 32'(dataValid), 32'(e_dv));
         chk("model_readData", 32'(readData), 32'(e_rd));
      end
   end

   // ---------------- directed helpers (called at a negedge) ----------------
   task automatic load_chk(input logic [AW-1:0] a, input logic [DW-1:0] req);
      memRead = 1'b1;
      address = a;
      @(negedge clk);
      memRead = 1'b0;
      chk("ld_busy0", 32'(busy), 1);
      chk("ld_dv0", 32'(dataValid), 0);
      @(negedge clk);
      chk("ld_busy1", 32'(busy), 1);
      chk("ld_dv1", 32'(dataValid), 0);
      @(negedge clk);
      chk("ld_busy2", 32'(busy), 0);
      chk("ld_dv2", 32'(dataValid), 1);
      chk("ld_data", 32'(readData), 32'(req));
   endtask

   task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic both);
      logic [DW-1:0] rd_before;
      rd_before = readData;
      memWrite  = 1'b1;
      memRead   = both;
      address   = a;
      writeData = d;
      @(negedge clk);
      memWrite = 1'b0;
      memRead  = 1'b0;
      chk("st_busy0", 32'(busy), 1);
      @(negedge clk);
      chk("st_busy1", 32'(busy), 1);
      chk("st_dv1", 32'(dataValid), 0);
      @(negedge clk);
      chk("st_busy2", 32'(busy), 0);
      chk("st_dv2", 32'(dataValid), 0);
      chk("st_rd_held", 32'(readData), 32'(rd_before));
   endtask

   initial begin
      reset     = 1'b1;
      memRead   = 1'b0;
      memWrite  = 1'b0;
      address   = '0;
      writeData = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_dv", 32'(dataValid), 0);
      chk("rst_rd", 32'(readData), 0);
      reset = 1'b0;

`ifdef DMEM_INIT_PATTERN_EN
      load_chk(5'd5, 8'h05);
`else
      load_chk(5'd5, 8'h00);
`endif

      // store then load
      store(5'd3, 8'hA7, 1'b0);
      load_chk(5'd3, 8'hA7);

      // store attempt while busy must be ignored
      memRead = 1'b1;
      address = 5'd3;
      @(negedge clk);
      memRead   = 1'b0;
      memWrite  = 1'b1;
      writeData = 8'h11;
      chk("ign_busy", 32'(busy), 1);
      @(negedge clk);
      memWrite = 1'b0;
      @(negedge clk);
      chk("ign_dv", 32'(dataValid), 1);
      chk("ign_rd", 32'(readData), 32'h A7);
      load_chk(5'd3, 8'hA7);

      // simultaneous read+write acts as a store
      store(5'd9, 8'h5C, 1'b1);
      chk("sim_rd_unchanged", 32'(readData), 32'hA7);
      load_chk(5'd9, 8'h5C);

      // reset mid-store aborts it
      memWrite  = 1'b1;
      address   = 5'd1;
      writeData = 8'hFF;
      @(negedge clk);
      memWrite = 1'b0;
      reset    = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_busy", 32'(busy), 0);
      chk("abort_rd", 32'(readData), 0);
`ifdef DMEM_INIT_PATTERN_EN
      load_chk(5'd1, 8'h01);
`else
      load_chk(5'd1, 8'h00);
`endif

      // back-to-back loads, second one at the maximum address
      store(5'd31, 8'h3C, 1'b0);
      store(5'd0, 8'hC3, 1'b0);
      load_chk(5'd0, 8'hC3);
      load_chk(5'd31, 8'h3C);

      // randomized traffic against the model
      for (int n = 0; n < 800; n++) begin
         memRead   = ($urandom_range(0, 2) == 0);
         memWrite  = ($urandom_range(0, 2) == 0);
         address   = AW'($urandom);
         writeData = DW'($urandom);
         reset     = ($urandom_range(0, 99) == 0);
         @(negedge clk);
      end
      memRead  = 1'b0;
      memWrite = 1'b0;
      reset    = 1'b0;
      repeat (LAT + 3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/data_mem_port.md
Name: data_mem_port

Overview:
- Synchronous data-memory block that supplies the memory-side operand of the register write-back path.
- Serves load and store requests from the control path against an internal byte array.
- Inserts a fixed number of wait states per access. Reports completion with a one-cycle valid pulse and a busy flag so the control FSM can stall.
- Its readData feeds the write-back selector's MemoryData input.

Parameters:
- ADDR_WIDTH, 5, address bits; array depth = 2**ADDR_WIDTH bytes.
- DATA_WIDTH, 8, word width; matches the datapath.
- LATENCY, 2, clock edges from request capture to completion; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- memRead  input  1  load request; sampled only in IDLE.
- memWrite  input  1  store request; sampled only in IDLE.
- address  input  ADDR_WIDTH  byte address; captured with the request.
- writeData  input  DATA_WIDTH  store data; captured with the request.
- readData  output  DATA_WIDTH  load result; holds its value between loads.
- dataValid  output  1  one-cycle pulse when a load completes.
- busy  output  1  high while an access is in progress.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values:
  - state=IDLE, busy=0, dataValid=0, readData=0, wait counter=0.
  - Every array location cleared to 0. See Optional Feature for the alternative.
- Reset asserted mid-access aborts the access: a pending store is NOT committed and dataValid is not pulsed.
- States:
  - IDLE: busy=0. On an edge with memRead|memWrite high, capture address, writeData and op type. Load counter with LATENCY-1 and go to WAIT.
  - WAIT: busy=1. Decrement counter each edge. On the edge where counter==0, perform the access and go to IDLE.
- Access at completion edge:
  - Store: mem[addr] <= data.
  - Load: readData <= mem[addr]; dataValid <= 1 for exactly one cycle.
- Timing: request sampled at edge t0 → busy high during cycles t0..t0+LATENCY-1 → completion at edge t0+LATENCY. busy is already 0 in the cycle where dataValid=1.
- Back-to-back: a new request may be sampled in the cycle where dataValid=1 (block is in IDLE). Sustained throughput is one access per LATENCY+1 cycles.
- Requests while busy are ignored, not queued. Inputs are don't-care in WAIT; captured values are used.
- memRead and memWrite both high in IDLE: treated as a store only. No dataValid, readData unchanged.
- readData changes only on load completion or reset. dataValid=0 for stores.
- Store then load to the same address: the load returns the stored value (store commits before the load is sampled).
- Address wraps naturally within ADDR_WIDTH. No out-of-range condition exists.

Optional Feature:
- Macro: DMEM_INIT_PATTERN_EN.
- Defined: reset writes mem[i] = i truncated to DATA_WIDTH for every i, giving deterministic non-zero data for bring-up programs.
- Undefined: reset clears every location to 0.
- Port behaviour and timing are identical in both builds.

Test Plan:
- Reset: assert reset 2 cycles → busy=0, dataValid=0, readData=0x00. A load from addr 5 then returns 0x00, or 0x05 with DMEM_INIT_PATTERN_EN.
- Store/load: store 0xA7 to addr 3 → busy high 2 cycles, no dataValid. Then load addr 3 → dataValid pulses exactly 2 edges after capture, readData=0xA7, held afterwards.
- Busy ignore: during a load of addr 3, pulse memWrite with addr 3, data 0x11 while busy=1 → ignored. A later load of addr 3 still returns 0xA7.
- Simultaneous: memRead=memWrite=1, addr 9, data 0x5C → no dataValid, readData unchanged. A load of addr 9 then returns 0x5C.
- Abort: start a store of 0xFF to addr 1, assert reset at cycle t0+1 → after reset, a load of addr 1 returns the reset value, not 0xFF.
- Back-to-back: issue a load of addr 0 and, in its dataValid cycle, a load of addr 31 → two dataValid pulses 3 cycles apart with correct data; addr 31 = maximum address, no wrap error.
